// File: rtl/bus_fabric_if.sv
// Bus bundle between one master, the fabric and NSLAVE memory-mapped slaves.
// Handshakes: the master holds m_req for an IDLE edge and the fabric answers with a one-cycle m_ack
// (m_err flags a failed transfer); a slave sees s_sel[k] high and ends the access with s_ack[k].
interface bus_fabric_if #(
   parameter int NSLAVE  = 8,
   parameter int AW      = 16,
   parameter int DW      = 16,
   parameter int SELBITS = 4
);
   logic                      m_req;
   logic                      m_we;
   logic [AW-1:0]             m_addr;
   logic [DW-1:0]             m_wdata;
   logic [DW-1:0]             m_rdata;
   logic                      m_ack;
   logic                      m_err;
   logic                      m_busy;
   logic [NSLAVE-1:0]         s_sel;
   logic                      s_we;
   logic [AW-SELBITS-1:0]     s_addr;
   logic [DW-1:0]             s_wdata;
   logic [NSLAVE*DW-1:0]      s_rdata;
   logic [NSLAVE-1:0]         s_ack;
   logic [7:0]                err_count;
   logic [AW-1:0]             err_addr;

   modport fabric (
      input  m_req, m_we, m_addr, m_wdata, s_rdata, s_ack,
      output m_rdata, m_ack, m_err, m_busy, s_sel, s_we, s_addr, s_wdata, err_count, err_addr
   );

   modport master (
      output m_req, m_we, m_addr, m_wdata,
      input  m_rdata, m_ack, m_err, m_busy, err_count, err_addr
   );

   modport slave (
      input  s_sel, s_we, s_addr, s_wdata,
      output s_rdata, s_ack
   );
endinterface

// File: rtl/bus_fabric.sv
// Single-master address-decoding fabric: IDLE -> ACCESS -> DONE per transfer, with decode
// and wait-timeout errors, a saturating error counter and last-error address capture.
module bus_fabric #(
   parameter int NSLAVE  = 8,
   parameter int AW      = 16,
   parameter int DW      = 16,
   parameter int SELBITS = 4,
   parameter int TIMEOUT = 15
) (
   input  logic                CLK,
   input  logic                RST,
   bus_fabric_if.fabric        bus,
   output logic [1:0]          dbg_state
);
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_e;

   localparam int              SW      = AW - SELBITS;
   localparam logic [SELBITS:0] NSL    = (SELBITS+1)'(NSLAVE);
   localparam logic [7:0]      TO_LAST = 8'(TIMEOUT - 1);

   state_e               state_q, state_d;
   logic                 we_q, we_d;
   logic [AW-1:0]        addr_q, addr_d;
   logic [DW-1:0]        wdata_q, wdata_d;
   logic [SELBITS-1:0]   idx_q, idx_d;
   logic                 err_q, err_d;
   logic [DW-1:0]        rdata_q, rdata_d;
   logic [7:0]           wait_q, wait_d;
   logic [7:0]           err_count_q, err_count_d;
   logic [AW-1:0]        err_addr_q, err_addr_d;

   logic                 ack_hit;
   logic                 err_event;
   logic [DW-1:0]        rd_slice;
   logic [NSLAVE-1:0]    sel_hot;
   logic [SELBITS-1:0]   req_idx;

   assign req_idx = bus.m_addr[AW-1 -: SELBITS];

   // Only the addressed slave's ack and read data are visible to the FSM.
   always_comb begin
      ack_hit  = 1'b0;
      rd_slice = '0;
      sel_hot  = '0;
      for (int k = 0; k < NSLAVE; k++) begin
         if (idx_q == SELBITS'(k)) begin
            sel_hot[k] = 1'b1;
            ack_hit    = bus.s_ack[k];
            rd_slice   = bus.s_rdata[k*DW +: DW];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      idx_d       = idx_q;
      err_d       = err_q;
      rdata_d     = rdata_q;
      wait_d      = wait_q;
      err_count_d = err_count_q;
      err_addr_d  = err_addr_q;
      err_event   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.m_req) begin
               we_d    = bus.m_we;
               addr_d  = bus.m_addr;
               wdata_d = bus.m_wdata;
               idx_d   = req_idx;
               wait_d  = 8'd0;
               if ({1'b0, req_idx} < NSL) begin
                  state_d = ACCESS;
                  err_d   = 1'b0;
               end else begin
                  state_d   = DONE;
                  err_d     = 1'b1;
                  rdata_d   = '1;
                  err_event = 1'b1;
               end
            end
         end
         ACCESS: begin
            // An ack on the timeout edge still wins: it is checked first.
            if (ack_hit) begin
               state_d = DONE;
               err_d   = 1'b0;
               rdata_d = we_q ? '0 : rd_slice;
            end else if (wait_q == TO_LAST) begin
               state_d   = DONE;
               err_d     = 1'b1;
               rdata_d   = '1;
               err_event = 1'b1;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (err_event) begin
         if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
         err_addr_d = addr_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= IDLE;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         idx_q       <= '0;
         err_q       <= 1'b0;
         rdata_q     <= '0;
         wait_q      <= 8'd0;
         err_count_q <= 8'd0;
         err_addr_q  <= '0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         idx_q       <= idx_d;
         err_q       <= err_d;
         rdata_q     <= rdata_d;
         wait_q      <= wait_d;
         err_count_q <= err_count_d;
         err_addr_q  <= err_addr_d;
      end
   end

   assign bus.m_busy    = (state_q != IDLE);
   assign bus.m_ack     = (state_q == DONE);
   assign bus.m_err     = (state_q == DONE) && err_q;
   assign bus.m_rdata   = rdata_q;
   assign bus.s_sel     = (state_q == ACCESS) ? sel_hot : '0;
   assign bus.s_we      = we_q;
   assign bus.s_addr    = addr_q[SW-1:0];
   assign bus.s_wdata   = wdata_q;
   assign bus.err_count = err_count_q;
   assign bus.err_addr  = err_addr_q;
   assign dbg_state     = state_q;
endmodule
